// File: rtl/header_tx.sv
// Transmit-side framer: sends each 16-bit bus word to a byte-wide UART as
// header, high byte, low byte, with a one-word holding buffer in front.
//
// state    | meaning
// ---------|---------------------------------------------------------------
// ST_IDLE  | no frame active; unloads the holding buffer when it is full
// ST_START | one-cycle tx_start_o pulse with the current byte on tx_byte_o
// ST_WAIT  | byte on the wire; waiting for tx_done_i
// ST_GAP   | inter-byte idle time after tx_done_i (only when GAP > 0)
module header_tx #(
    parameter logic [7:0]  HEADER = 8'h80,
    parameter int unsigned GAP    = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        io_stb_i,
    input  logic        io_we_i,
    input  logic [15:0] data_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic [7:0]  tx_byte_o,
    output logic        tx_start_o,
    input  logic        tx_done_i,
    output logic        frame_done_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_GAP
    } state_t;

    localparam logic [7:0] GAP_CYC = 8'(GAP);

    state_t      state_q, state_d;
    logic [15:0] buf_q, buf_d;
    logic        buf_full_q, buf_full_d;
    logic [15:0] frame_q, frame_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  byte_q, byte_d;
    logic        advance;
    logic        accept;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            buf_q      <= 16'h0000;
            buf_full_q <= 1'b0;
            frame_q    <= 16'h0000;
            idx_q      <= 2'd0;
            gap_q      <= 8'd0;
            byte_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            byte_q     <= byte_d;
        end
    end

    // Accept and unload are mutually exclusive: accept needs an empty buffer,
    // unload needs a full one, so a write racing the unload is simply refused.
    assign accept = io_stb_i & io_we_i & ~buf_full_q;

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        frame_d      = frame_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        byte_d       = byte_q;
        advance      = 1'b0;
        frame_done_o = 1'b0;

        if (accept) begin
            buf_d      = data_i;
            buf_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (buf_full_q) begin
                    frame_d    = buf_q;
                    buf_full_d = 1'b0;
                    idx_d      = 2'd0;
                    byte_d     = HEADER;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done_i) begin
                    frame_done_o = (idx_q == 2'd2);
                    if (GAP_CYC != 8'd0) begin
                        gap_d   = GAP_CYC;
                        state_d = ST_GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q == 8'd1) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Common exit from WAIT/GAP: next byte of the frame, or back to idle.
        if (advance) begin
            if (idx_q == 2'd2) begin
                state_d = ST_IDLE;
            end else begin
                idx_d   = idx_q + 2'd1;
                byte_d  = (idx_q == 2'd0) ? frame_q[15:8] : frame_q[7:0];
                state_d = ST_START;
            end
        end
    end

    assign ready_o    = ~buf_full_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign tx_start_o = (state_q == ST_START);
    assign tx_byte_o  = byte_q;

endmodule

// File: tb/tb_header_tx.sv
// Scoreboard bench for header_tx: lane 0 runs GAP=0, lane 1 runs GAP=3, each
// with its own UART responder; expected bytes are queued as {lane, byte}.
module tb_header_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        stb[2];
    logic        we[2];
    logic [15:0] data[2];
    logic        mdone[2];
    logic        inj[2];
    logic        done[2];
    logic        ready[2];
    logic        busy[2];
    logic        start[2];
    logic        fdone[2];
    logic [7:0]  txb[2];

    assign done[0] = mdone[0] | inj[0];
    assign done[1] = mdone[1] | inj[1];

    header_tx #(.HEADER(8'h80), .GAP(0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .io_stb_i(stb[0]), .io_we_i(we[0]),
        .data_i(data[0]), .ready_o(ready[0]), .busy_o(busy[0]),
        .tx_byte_o(txb[0]), .tx_start_o(start[0]), .tx_done_i(done[0]),
        .frame_done_o(fdone[0])
    );

    header_tx #(.HEADER(8'h80), .GAP(3)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .io_stb_i(stb[1]), .io_we_i(we[1]),
        .data_i(data[1]), .ready_o(ready[1]), .busy_o(busy[1]),
        .tx_byte_o(txb[1]), .tx_start_o(start[1]), .tx_done_i(done[1]),
        .frame_done_o(fdone[1])
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cnt[2];
    int          gapc[2];
    int          since[2];
    int          bif[2];
    int          starts[2];
    int          fdones[2];
    logic        inj_en[2];
    logic        busy_prev[2];
    logic [7:0]  last_byte[2];
    logic [8:0]  exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // UART responder: tx_done_i 10 cycles after each tx_start_o; optional
    // spurious tx_done_i pulses during START and the GAP window.
    always @(posedge clk) begin
        #1;
        for (int l = 0; l < 2; l++) begin
            if (!rst_n) begin
                cnt[l] = 0; gapc[l] = 0; mdone[l] = 1'b0; inj[l] = 1'b0;
            end else begin
                mdone[l] = 1'b0;
                inj[l]   = 1'b0;
                if (gapc[l] > 0) begin
                    inj[l] = inj_en[l];
                    gapc[l]--;
                end
                if (start[l]) begin
                    cnt[l] = 10;
                    inj[l] = inj_en[l];
                end else if (cnt[l] > 0) begin
                    cnt[l]--;
                    if (cnt[l] == 0) begin
                        mdone[l] = 1'b1;
                        gapc[l]  = (l == 1) ? 3 : 0;
                    end
                end
            end
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [8:0] e;
        logic [8:0] obs9;
        int         gap_l;
        for (int l = 0; l < 2; l++) begin
            gap_l = (l == 1) ? 3 : 0;
            if (!rst_n) begin
                since[l] = -1; bif[l] = 0; busy_prev[l] = 1'b0;
            end else begin
                if (mdone[l]) begin
                    chk($sformatf("byte_stable_l%0d", l), 32'(txb[l]), 32'(last_byte[l]));
                    since[l] = 0;
                end else if (since[l] >= 0) begin
                    since[l]++;
                end
                if (start[l] | fdone[l])
                    chk($sformatf("start_fdone_excl_l%0d", l), 32'(start[l] & fdone[l]), 0);
                if (start[l]) begin
                    starts[l]++;
                    bif[l]++;
                    if (since[l] >= 0)
                        chk($sformatf("gap_to_start_l%0d", l), since[l], gap_l + 1);
                    since[l] = -1;
                    last_byte[l] = txb[l];
                    obs9 = {l[0], txb[l]};
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_start", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", 32'(obs9), 32'(e));
                    end
                end
                if (fdone[l]) begin
                    fdones[l]++;
                    chk($sformatf("fdone_on_done_l%0d", l), 32'(mdone[l]), 1);
                    chk($sformatf("fdone_pos_l%0d", l), bif[l], 3);
                    bif[l] = 0;
                end
                if (busy_prev[l] && !busy[l]) begin
                    if (since[l] >= 0)
                        chk($sformatf("gap_to_idle_l%0d", l), since[l], gap_l + 1);
                    since[l] = -1;
                end
                busy_prev[l] = busy[l];
            end
        end
    end

    task automatic push3(input int l, input logic [15:0] w);
        exp_q.push_back({l[0], 8'h80});
        exp_q.push_back({l[0], w[15:8]});
        exp_q.push_back({l[0], w[7:0]});
    endtask

    task automatic wr(input int l, input logic [15:0] d);
        @(negedge clk);
        stb[l] = 1'b1; we[l] = 1'b1; data[l] = d;
        @(negedge clk);
        stb[l] = 1'b0; we[l] = 1'b0;
    endtask

    task automatic wait_starts(input int l, input int n);
        int t = 0;
        while (starts[l] < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("wait_starts_l%0d", l), 32'(starts[l] >= n), 1);
    endtask

    task automatic wait_idle(input int l);
        int t = 0;
        while (!(exp_q.size() == 0 && !busy[l] && ready[l]) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("idle_reached_l%0d", l), 32'(exp_q.size() == 0 && !busy[l]), 1);
    endtask

    initial begin
        int base, fd;
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int base, fd;
        for (int l = 0; l < 2; l++) begin
            stb[l] = 1'b0; we[l] = 1'b0; data[l] = 16'h0000; inj_en[l] = 1'b0;
            mdone[l] = 1'b0; inj[l] = 1'b0; cnt[l] = 0; gapc[l] = 0;
            since[l] = -1; bif[l] = 0; starts[l] = 0; fdones[l] = 0;
            busy_prev[l] = 1'b0; last_byte[l] = 8'h00;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            chk("rst_ready", 32'(ready[l]), 1);
            chk("rst_busy", 32'(busy[l]), 0);
            chk("rst_tx_byte", 32'(txb[l]), 0);
            chk("rst_tx_start", 32'(start[l]), 0);
            chk("rst_fdone", 32'(fdone[l]), 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single frame, GAP=0, latency
        push3(0, 16'hA55A);
        wr(0, 16'hA55A);
        chk("t1_ready_after_accept", 32'(ready[0]), 0);
        chk("t1_no_early_start", 32'(start[0]), 0);
        @(negedge clk);
        chk("t1_start_latency", 32'(start[0]), 1);
        chk("t1_ready_after_unload", 32'(ready[0]), 1);
        wait_idle(0);
        chk("t1_fdone_count", fdones[0], 1);
        chk("t1_busy_end", 32'(busy[0]), 0);

        // 2: buffered second word, third write refused
        push3(0, 16'h1234);
        wr(0, 16'h1234);
        wait_starts(0, 4);
        @(negedge clk);
        chk("t2_ready_in_wait", 32'(ready[0]), 1);
        push3(0, 16'hBEEF);
        wr(0, 16'hBEEF);
        chk("t2_ready_full", 32'(ready[0]), 0);
        wr(0, 16'h5555);
        chk("t2_ready_still_full", 32'(ready[0]), 0);
        wait_idle(0);
        chk("t2_fdone_count", fdones[0], 3);

        // 3: GAP=3 timing on lane 1
        push3(1, 16'h00FF);
        wr(1, 16'h00FF);
        wait_idle(1);
        chk("t3_fdone_count", fdones[1], 1);

        // 4: header-valued data, spurious tx_done_i in START/GAP
        inj_en[1] = 1'b1;
        push3(1, 16'h8080);
        wr(1, 16'h8080);
        wait_idle(1);
        inj_en[1] = 1'b0;
        chk("t4_fdone_count", fdones[1], 2);

        // 5: async reset during high-byte WAIT with buffer full
        base = starts[0];
        fd = fdones[0];
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b0, 8'h11});
        wr(0, 16'h1111);
        wait_starts(0, base + 1);
        wr(0, 16'h2222);
        wait_starts(0, base + 2);
        repeat (2) @(negedge clk);
        chk("t5_buf_full", 32'(ready[0]), 0);
        chk("t5_busy_before", 32'(busy[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(ready[0]), 1);
        chk("t5_rst_busy", 32'(busy[0]), 0);
        chk("t5_rst_tx_byte", 32'(txb[0]), 0);
        chk("t5_rst_tx_start", 32'(start[0]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("t5_no_resume", starts[0], base + 2);
        chk("t5_no_fdone", fdones[0], fd);
        chk("t5_sb_empty", exp_q.size(), 0);
        chk("t5_idle", 32'(busy[0]), 0);

        // 6: strobe without write enable
        base = starts[0];
        @(negedge clk);
        stb[0] = 1'b1; we[0] = 1'b0; data[0] = 16'h7777;
        repeat (20) @(negedge clk);
        chk("t6_ready", 32'(ready[0]), 1);
        stb[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_no_start", starts[0], base);
        chk("t6_busy", 32'(busy[0]), 0);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/header_tx.md
Name: header_tx

Overview:
Transmit-side framer for the IO hub serial link. It takes 16-bit words from the IO bus and sends each one to the byte-wide UART transmitter as a 3-byte frame: header, high byte, low byte. This matches the frame format our header receiver decodes. A one-word holding buffer lets the bus post the next word while the current frame is on the wire.

Parameters:
HEADER, 8'h80, first byte of every frame.
GAP, 0, idle clock cycles inserted after each byte's tx_done_i, before the next byte or frame starts (0..255).

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_n_i  input  1  asynchronous active-low reset
io_stb_i  input  1  bus strobe
io_we_i  input  1  bus write enable
data_i  input  16  word to transmit
ready_o  output  1  holding buffer empty; a write is accepted only when this is 1
busy_o  output  1  frame in progress (any state other than IDLE)
tx_byte_o  output  8  byte presented to UART transmitter
tx_start_o  output  1  one-cycle pulse telling the UART to latch tx_byte_o
tx_done_i  input  1  one-cycle pulse from the UART when the byte has been fully shifted out
frame_done_o  output  1  one-cycle pulse when the low byte's tx_done_i is sampled

Behaviour:
- Reset (rst_n_i=0, async):
  - state=IDLE, buffer empty, byte index=0, gap counter=0.
  - Outputs: ready_o=1, busy_o=0, tx_byte_o=8'h00, tx_start_o=0, frame_done_o=0.
  - Reset mid-frame aborts the frame and discards the buffered word; nothing resumes after release.
- Accept:
  - On an edge with io_stb_i & io_we_i & ready_o, data_i is captured into the buffer and ready_o goes 0.
  - A write while ready_o=0 is ignored; the buffer keeps its contents.
  - ready_o depends only on buffer occupancy. It is not asserted combinationally in the same cycle the buffer is unloaded.
- State machine: IDLE, START, WAIT, GAP.
  - IDLE: if the buffer is full, move the word into the frame register, clear the buffer (ready_o=1 next cycle), set index=0 and go to START.
  - START: tx_start_o=1 for exactly this cycle; tx_byte_o = HEADER for index 0, frame[15:8] for index 1, frame[7:0] for index 2. Always go to WAIT.
  - WAIT: hold tx_byte_o stable and wait for tx_done_i.
    - On tx_done_i with GAP=0: index<2 → index+1 and go to START; index=2 → pulse frame_done_o and go to IDLE.
    - On tx_done_i with GAP>0: load the counter with GAP and go to GAP. frame_done_o still pulses on the tx_done_i cycle when index=2.
  - GAP: decrement the counter each cycle. At 1 → go to START (index+1) if index<2, otherwise IDLE.
- tx_done_i is ignored in IDLE, START and GAP.
- Latency: write accepted at edge k → tx_start_o high during the cycle after edge k+1 (header). Back-to-back frames with GAP=0: IDLE lasts one cycle between frames.
- Simultaneous events: a bus write in the same cycle IDLE unloads the buffer is not accepted (ready_o=0 that cycle). The bus retries.
- tx_byte_o holds its last value in IDLE/GAP. Only START changes it.
- frame_done_o and tx_start_o are never high in the same cycle.
- HEADER is sent verbatim, even if a data byte equals HEADER. No escaping; the receiver is position-based.

Test Plan:
1. Reset, write 16'hA55A, UART model returns tx_done_i 10 cycles after each tx_start_o, GAP=0 → bytes 80, A5, 5A each with exactly one tx_start_o pulse; frame_done_o once; busy_o 0 afterward.
2. Write 16'h1234, then write 16'hBEEF while the header is in WAIT → second write accepted (ready_o was 1); bytes 80,12,34,80,BE,EF; a third write during frame 1 with a full buffer is ignored.
3. GAP=3, write 16'h00FF → exactly 3 idle cycles between each tx_done_i and the next tx_start_o; 3 idle cycles after the last byte before IDLE; bytes 80,00,FF.
4. Write 16'h8080 → bytes 80,80,80 sent unmodified; tx_done_i pulses injected during START/GAP have no effect.
5. Assert rst_n_i low asynchronously mid-cycle during the high byte's WAIT with the buffer full → outputs return to reset values immediately; after release no bytes are sent until a new write.
6. Hold io_stb_i=1, io_we_i=0 with data_i=16'h7777 → nothing accepted; ready_o stays 1; no tx_start_o.
